// File: rtl/conv_window_sequencer_if.sv
// Handshake/bus bundle between the window sequencer and the
// ROM / line_buffer / matrix_3x3 filter path.
interface conv_window_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              frame_start;
  logic              row_req;
  logic              fifo_rst_busy;
  logic              rom_rd_en;
  logic [ADDR_W-1:0] rom_addr;
  logic              buffer_valid_in;
  logic              rd_en_all;
  logic              rst_fifo;
  logic              matrix_valid_in;
  logic              busy;
  logic              frame_done;
  logic              row_miss;

  modport master (
    input  frame_start,
    input  row_req,
    input  fifo_rst_busy,
    output rom_rd_en,
    output rom_addr,
    output buffer_valid_in,
    output rd_en_all,
    output rst_fifo,
    output matrix_valid_in,
    output busy,
    output frame_done,
    output row_miss
  );

  modport slave (
    output frame_start,
    output row_req,
    output fifo_rst_busy,
    input  rom_rd_en,
    input  rom_addr,
    input  buffer_valid_in,
    input  rd_en_all,
    input  rst_fifo,
    input  matrix_valid_in,
    input  busy,
    input  frame_done,
    input  row_miss
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Frame controller: flush line FIFOs, preload three lines,
// then emit one filtered row per row request.
module conv_window_sequencer #(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int ADDR_W     = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic                    lcd_pclk,
  input  logic                    rst,
  conv_window_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIFO_RST,
    S_WAIT_BUSY,
    S_PRELOAD,
    S_WAIT_ROW,
    S_ROW,
    S_DONE
  } state_t;

  localparam int PIX_W = $clog2(PIC_WIDTH);
  localparam int ROW_W = $clog2(PIC_HEIGHT - 2);
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIC_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(PIC_HEIGHT - 3);
  localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(3 * PIC_WIDTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [RST_W-1:0]  rcnt_q, rcnt_d;
  logic              bvi_q, bvi_d;
  logic              mvi_q, mvi_d;
  logic              miss_q, miss_d;

  logic rd;
  logic rden;
  logic rstf;
  logic done;

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    row_d   = row_q;
    rcnt_d  = rcnt_q;
    rd      = 1'b0;
    rden    = 1'b0;
    rstf    = 1'b1;
    done    = 1'b0;
    miss_d  = bus.row_req && (state_q != S_WAIT_ROW);

    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          state_d = S_FIFO_RST;
          addr_d  = '0;
          rcnt_d  = '0;
          row_d   = '0;
        end
      end
      S_FIFO_RST: begin
        rstf = 1'b0;
        if (rcnt_q == RST_LAST) begin
          state_d = S_WAIT_BUSY;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        if (!bus.fifo_rst_busy) begin
          state_d = S_PRELOAD;
        end
      end
      S_PRELOAD: begin
        // A busy FIFO stalls the stream in place: no read, no advance.
        if (!bus.fifo_rst_busy) begin
          rd     = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == PRE_LAST) begin
            state_d = S_WAIT_ROW;
          end
        end
      end
      S_WAIT_ROW: begin
        if (bus.row_req) begin
          state_d = S_ROW;
          pix_d   = '0;
        end
      end
      S_ROW: begin
        rden = 1'b1;
        // The last output row has no further ROM line to stream in.
        if (row_q < ROW_LAST) begin
          rd     = 1'b1;
          addr_d = addr_q + 1'b1;
        end
        if (pix_q == PIX_LAST) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_WAIT_ROW;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    bvi_d = rd;
    mvi_d = rden;
  end

  // State, counters and one-cycle-delayed strobes.
  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pix_q   <= '0;
      row_q   <= '0;
      rcnt_q  <= '0;
      bvi_q   <= 1'b0;
      mvi_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      row_q   <= row_d;
      rcnt_q  <= rcnt_d;
      bvi_q   <= bvi_d;
      mvi_q   <= mvi_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.rom_rd_en       = rd;
  assign bus.rom_addr        = addr_q;
  assign bus.buffer_valid_in = bvi_q;
  assign bus.rd_en_all       = rden;
  assign bus.rst_fifo        = rstf;
  assign bus.matrix_valid_in = mvi_q;
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.frame_done      = done;
  assign bus.row_miss        = miss_q;

endmodule
